// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and sizing helpers for the fully-connected layer control
package cnn_pkg;

  // Sequencer states of the fully-connected layer controller
  typedef enum logic [2:0] {
    FC_IDLE    = 3'd0,
    FC_FETCH   = 3'd1,
    FC_WAIT    = 3'd2,
    FC_CAPTURE = 3'd3,
    FC_STORE   = 3'd4,
    FC_DONE    = 3'd5
  } fc_state_t;

  // Integer ceiling division, used to derive the number of passes per layer
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Address width for a count of items; never below 1 bit even for a single pass
  function automatic int clog2_min2(input int value);
    int v;
    int w;
    v = (value < 2) ? 2 : value;
    w = 0;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/fc_result_buffer.sv
// rtl/fc_result_buffer.sv - NEURONS-slot layer result register with lane-to-slot writes
module fc_result_buffer
  import cnn_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int FILTERBATCH = 1,
  parameter int NEURONS     = 10,
  parameter int PASS_AW     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [PASS_AW-1:0]                pass,
  input  logic [2*BITWIDTH*FILTERBATCH-1:0] lanes,
  output logic [2*BITWIDTH*NEURONS-1:0]     result
);

  localparam int SW = 2 * BITWIDTH;

  // Each slot is owned by exactly one (pass, lane) pair. Lanes of a partial last
  // pass that would land past NEURONS own no slot, so they are dropped for free.
  for (genvar i = 0; i < NEURONS; i++) begin : g_slot
    localparam int LANE  = i % FILTERBATCH;
    localparam int OWNER = i / FILTERBATCH;

    logic [SW-1:0] slot_q;

    // Capture the owning lane when its pass is stored; hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else if (wr_en && (pass == PASS_AW'(OWNER))) begin
        slot_q <= lanes[LANE*SW +: SW];
      end
    end

    assign result[i*SW +: SW] = slot_q;
  end

endmodule

// File: rtl/fc_scheduler.sv
// rtl/fc_scheduler.sv - pass sequencer feeding weight slices to one FullConnect datapath
module fc_scheduler
  import cnn_pkg::*;
#(
  parameter int  BITWIDTH    = 8,
  parameter int  LENGTH      = 25,
  parameter int  FILTERBATCH = 1,
  parameter int  NEURONS     = 10,
  localparam int PASSES      = ceil_div(NEURONS, FILTERBATCH),
  localparam int PASS_AW     = clog2_min2(PASSES)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [BITWIDTH*LENGTH-1:0]               in_data,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     w_rd_en,
  output logic [PASS_AW-1:0]                       w_addr,
  input  logic [BITWIDTH*LENGTH*FILTERBATCH-1:0]   w_rdata,
  input  logic [BITWIDTH*FILTERBATCH-1:0]          b_rdata,
  output logic                                     fc_clken,
  output logic [BITWIDTH*LENGTH-1:0]               fc_data,
  output logic [BITWIDTH*LENGTH*FILTERBATCH-1:0]   fc_weight,
  output logic [BITWIDTH*FILTERBATCH-1:0]          fc_bias,
  input  logic [2*BITWIDTH*FILTERBATCH-1:0]        fc_result,
  output logic [2*BITWIDTH*NEURONS-1:0]            result
);

  localparam logic [PASS_AW-1:0] LAST_PASS = PASS_AW'(PASSES - 1);

  fc_state_t          state;
  logic [PASS_AW-1:0] pass;

  // Strobes are pure decodes of the state register, so no input reaches an output
  assign busy     = (state != FC_IDLE);
  assign done     = (state == FC_DONE);
  assign w_rd_en  = (state == FC_FETCH);
  assign fc_clken = (state == FC_CAPTURE);
  assign w_addr   = pass;

  // Sequence FETCH -> WAIT -> CAPTURE -> STORE once per pass, then a one-cycle DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FC_IDLE;
      pass  <= '0;
    end else begin
      case (state)
        FC_IDLE: begin
          if (start) begin
            pass  <= '0;
            state <= FC_FETCH;
          end
        end
        FC_FETCH:   state <= FC_WAIT;
        FC_WAIT:    state <= FC_CAPTURE;
        FC_CAPTURE: state <= FC_STORE;
        FC_STORE: begin
          if (pass == LAST_PASS) begin
            state <= FC_DONE;
          end else begin
            pass  <= pass + PASS_AW'(1);
            state <= FC_FETCH;
          end
        end
        FC_DONE:    state <= FC_IDLE;
        default:    state <= FC_IDLE;
      endcase
    end
  end

  // Latch the input vector on an accepted start and the memory slice one cycle after the read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_data   <= '0;
      fc_weight <= '0;
      fc_bias   <= '0;
    end else begin
      if ((state == FC_IDLE) && start) begin
        fc_data <= in_data;
      end
      if (state == FC_WAIT) begin
        fc_weight <= w_rdata;
        fc_bias   <= b_rdata;
      end
    end
  end

  fc_result_buffer #(
    .BITWIDTH    (BITWIDTH),
    .FILTERBATCH (FILTERBATCH),
    .NEURONS     (NEURONS),
    .PASS_AW     (PASS_AW)
  ) u_result_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (state == FC_STORE),
    .pass   (pass),
    .lanes  (fc_result),
    .result (result)
  );

endmodule
